// File: rtl/fnd_pkg.sv
// Shared constants for the 7-segment display path.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package fnd_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to 7-segment decoder, active-high output.
// Non-decimal codes render as a dash so corrupted digits are visible.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/six_digit_scan.sv
// Six-digit multiplexed 7-segment driver with per-slot dead time.
// Inputs are snapshotted once per frame so a frame never mixes old and new data.
module six_digit_scan
    import fnd_pkg::*;
#(
    parameter int unsigned SCAN_DIV    = 50000,
    parameter int unsigned BLANK_CYC   = 500,
    parameter bit          SEG_ACT_LOW = 1'b1,
    parameter bit          COM_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] i_six_bcd,
    input  logic [5:0]  i_six_dp,
    input  logic [5:0]  i_six_blank,
    output logic [6:0]  o_seg,
    output logic        o_dp,
    output logic [5:0]  o_com,
    output logic        o_frame_tick
);

    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_MASK = {7{SEG_ACT_LOW}};
    localparam logic [5:0] COM_MASK = {6{COM_ACT_LOW}};

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          first_flag;
    logic [23:0]   bcd_snap;
    logic [5:0]    dp_snap;
    logic [5:0]    blank_snap;

    logic          slot_end;
    logic          snap;
    logic          drive;
    logic [3:0]    cur_bcd;
    seg_t          cur_seg;
    seg_t          seg_hi;
    logic          dp_hi;
    logic [5:0]    com_hi;

    assign slot_end = (cnt == CNT_MAX);
    assign snap     = first_flag || (slot_end && (idx == IDX_LAST));
    assign cur_bcd  = bcd_snap[{idx, 2'b00} +: 4];
    assign drive    = (cnt >= BLANK_END) && !blank_snap[idx];

    bcd_to_seg u_dec (
        .bcd (cur_bcd),
        .seg (cur_seg)
    );

    always_comb begin
        seg_hi = SEG_OFF;
        dp_hi  = 1'b0;
        com_hi = 6'b000000;
        if (drive) begin
            seg_hi = cur_seg;
            dp_hi  = dp_snap[idx];
            com_hi = 6'b000001 << idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= 3'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // first_flag forces a snapshot on the first edge out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_flag <= 1'b1;
            bcd_snap   <= 24'h000000;
            dp_snap    <= 6'b000000;
            blank_snap <= 6'b111111;
        end else begin
            first_flag <= 1'b0;
            if (snap) begin
                bcd_snap   <= i_six_bcd;
                dp_snap    <= i_six_dp;
                blank_snap <= i_six_blank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_seg        <= SEG_MASK;
            o_dp         <= SEG_ACT_LOW;
            o_com        <= COM_MASK;
            o_frame_tick <= 1'b0;
        end else begin
            o_seg        <= seg_hi ^ SEG_MASK;
            o_dp         <= dp_hi ^ SEG_ACT_LOW;
            o_com        <= com_hi ^ COM_MASK;
            o_frame_tick <= snap;
        end
    end

endmodule

// File: tb/tb_six_digit_scan.sv
// Directed bench for six_digit_scan with SCAN_DIV=8, BLANK_CYC=2, active-low pins.
// Expected segment codes per slot are hand-computed active-low patterns.
module tb_six_digit_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] i_six_bcd = 24'h123456;
    logic [5:0]  i_six_dp = 6'b010100;
    logic [5:0]  i_six_blank = 6'b000000;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [5:0]  o_com;
    logic        o_frame_tick;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    // active-low segment codes
    localparam logic [6:0] L1 = 7'h79, L2 = 7'h24, L3 = 7'h30;
    localparam logic [6:0] L4 = 7'h19, L5 = 7'h12, L6 = 7'h02;
    localparam logic [6:0] L9 = 7'h10, LD = 7'h3F;

    six_digit_scan #(
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .SEG_ACT_LOW (1'b1),
        .COM_ACT_LOW (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_six_bcd    (i_six_bcd),
        .i_six_dp     (i_six_dp),
        .i_six_blank  (i_six_blank),
        .o_seg        (o_seg),
        .o_dp         (o_dp),
        .o_com        (o_com),
        .o_frame_tick (o_frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        @(negedge clk);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_com"},  32'(o_com), 32'h3F);
        check({tag, "_seg"},  32'(o_seg), 32'h7F);
        check({tag, "_dp"},   32'(o_dp), 32'h1);
        check({tag, "_tick"}, 32'(o_frame_tick), 32'h0);
    endtask

    // Checks ncyc cycles of slot k; seg_exp is the active-low code when driven.
    task automatic check_slot(input int k, input logic [6:0] seg_exp, input logic dp_on,
                              input logic blank, input int ncyc);
        logic [5:0] com_on;
        logic       drv;
        logic       tick_exp;
        com_on = ~(6'b000001 << k);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            drv      = (c >= 2) && !blank;
            tick_exp = (t == 1) || ((t % 48) == 0);
            check($sformatf("s%0d_c%0d_com", k, c), 32'(o_com), drv ? 32'(com_on) : 32'h3F);
            check($sformatf("s%0d_c%0d_seg", k, c), 32'(o_seg), drv ? 32'(seg_exp) : 32'h7F);
            check($sformatf("s%0d_c%0d_dp", k, c),  32'(o_dp), (drv && dp_on) ? 32'h0 : 32'h1);
            check($sformatf("s%0d_c%0d_tick", k, c), 32'(o_frame_tick), 32'(tick_exp));
        end
    endtask

    // segs packs slot k code at [7k+:7]
    task automatic check_slots(input logic [41:0] segs, input logic [5:0] dp,
                               input logic [5:0] blank, input int first, input int last);
        for (int k = first; k <= last; k++)
            check_slot(k, segs[7*k +: 7], dp[k], blank[k], 8);
    endtask

    logic [41:0] frm_a, frm_9, frm_b;

    initial begin
        frm_a = {L1, L2, L3, L4, L5, L6};
        frm_9 = {L9, L9, L9, L9, L9, L9};
        frm_b = {L9, L9, L9, L9, L9, LD};

        // initial reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst0");
        rst = 1'b0;
        t   = 0;

        // frame 0: 123456 with dp on digits 2 and 4
        check_slots(frm_a, 6'b010100, 6'b000000, 0, 5);

        // frame 1: change inputs during slot 3; frame must stay old
        check_slots(frm_a, 6'b010100, 6'b000000, 0, 2);
        i_six_bcd = 24'h999999;
        check_slots(frm_a, 6'b010100, 6'b000000, 3, 5);

        // frame 2: new value; queue blank of digit 5 and dash on digit 0
        check_slots(frm_9, 6'b010100, 6'b000000, 0, 1);
        i_six_blank = 6'b100000;
        i_six_bcd   = 24'h99999B;
        check_slots(frm_9, 6'b010100, 6'b000000, 2, 5);

        // frame 3: digit 0 dash, digit 5 dark for its whole slot
        check_slots(frm_b, 6'b010100, 6'b100000, 0, 5);

        // frame 4: reset hits in slot 4 drive phase
        check_slots(frm_b, 6'b010100, 6'b100000, 0, 3);
        check_slot(4, L9, 1'b1, 1'b0, 4);
        rst = 1'b1;
        #1;
        check_reset_outs("rst_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("rst_hold");
        rst = 1'b0;
        t   = 0;

        // restart from idx 0, cnt 0; full frame then first slot of the next
        check_slots(frm_b, 6'b010100, 6'b100000, 0, 5);
        check_slots(frm_b, 6'b010100, 6'b100000, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
